// File: rtl/matrix_pkg.sv
// Shared constants, opcode encodings and FSM state type for the matrix ALU sequencer.
package matrix_pkg;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 25;
    localparam int FLAT_W = ELEM_W * N_ELEM;
    localparam int CNT_W  = 5;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [2:0]       opcode_t;

    localparam cnt_t LAST_IDX = cnt_t'(N_ELEM - 1);

    localparam opcode_t OP_NONE      = 3'b000;
    localparam opcode_t OP_SUM       = 3'b001;
    localparam opcode_t OP_SUB       = 3'b010;
    localparam opcode_t OP_MUL       = 3'b011;
    localparam opcode_t OP_OPPOSITE  = 3'b100;
    localparam opcode_t OP_TRANSPOSE = 3'b101;
    localparam opcode_t OP_SCALAR    = 3'b110;
    localparam opcode_t OP_ILLEGAL   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_A    = 3'd1,
        ST_LOAD_B    = 3'd2,
        ST_EXEC      = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_STREAM    = 3'd5
    } state_e;

    // 000 and 111 are reserved and rejected at command time.
    function automatic logic op_legal(input opcode_t op);
        return (op != OP_NONE) && (op != OP_ILLEGAL);
    endfunction

    // Only sum, sub and mul consume a second operand matrix.
    function automatic logic op_two_operand(input opcode_t op);
        return (op == OP_SUM) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/matrix_elem_serializer.sv
// Holds the latched ALU result and streams it out one element per accepted beat.
module matrix_elem_serializer
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [FLAT_W-1:0] c_flat,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last
);

    logic [FLAT_W-1:0] result;
    cnt_t              idx;
    cnt_t              idx_nxt;

    assign idx_nxt = idx + cnt_t'(1);

    // Result register, element index and registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the result register is a plain flop bank, not a RAM, so it is
        // reset along with the rest; a stale result can never leak after reset.
        if (!rst_n) begin
            result    <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            result    <= c_flat;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= c_flat[ELEM_W-1:0];
            out_last  <= 1'b0;
        end else if (out_valid && out_ready) begin
            if (out_last) begin
                idx       <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                idx      <= idx_nxt;
                out_data <= result[ELEM_W*idx_nxt +: ELEM_W];
                out_last <= (idx_nxt == LAST_IDX);
            end
        end
    end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Command/operand front end and result back end around a combinational 5x5 matrix ALU.
module matrix_op_sequencer
    import matrix_pkg::*;
#(
    parameter int DONE_TMO = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_opcode,
    input  logic [ELEM_W-1:0] cmd_scalar,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    output logic [FLAT_W-1:0] alu_A_flat,
    output logic [FLAT_W-1:0] alu_B_flat,
    output logic [ELEM_W-1:0] alu_f,
    output logic [2:0]        alu_opcode,
    input  logic [FLAT_W-1:0] alu_C_flat,
    input  logic              alu_ovf,
    input  logic              alu_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    output logic              status_ovf,
    output logic              status_err,
    output logic              busy
);

    localparam int TMO_W = $clog2(DONE_TMO + 1);

    state_e           state;
    state_e           state_nxt;
    opcode_t          op_q;
    cnt_t             elem_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             ser_load;
    logic             tmo_hit;
    logic             last_beat;

    assign tmo_hit   = (tmo_cnt == TMO_W'(DONE_TMO - 1));
    assign last_beat = in_valid && (elem_cnt == LAST_IDX);

    assign cmd_ready  = (state == ST_IDLE);
    assign in_ready   = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign busy       = (state != ST_IDLE);
    assign alu_opcode = ((state == ST_EXEC) || (state == ST_WAIT_DONE)) ? op_q : OP_NONE;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and result-latch strobe.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can
        // leave one unassigned and infer a latch.
        state_nxt = state;
        ser_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && op_legal(cmd_opcode)) state_nxt = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                if (last_beat) state_nxt = op_two_operand(op_q) ? ST_LOAD_B : ST_EXEC;
            end
            ST_LOAD_B: begin
                if (last_beat) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (alu_done) begin
                    ser_load  = 1'b1;
                    state_nxt = ST_STREAM;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (out_valid && out_ready && out_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command capture, operand loaders, timeout counter and sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_NONE;
            alu_f      <= '0;
            alu_A_flat <= '0;
            alu_B_flat <= '0;
            elem_cnt   <= '0;
            tmo_cnt    <= '0;
            status_ovf <= 1'b0;
            status_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q       <= cmd_opcode;
                        alu_f      <= cmd_scalar;
                        alu_A_flat <= '0;
                        alu_B_flat <= '0;
                        elem_cnt   <= '0;
                        status_ovf <= 1'b0;
                        status_err <= !op_legal(cmd_opcode);
                    end
                end
                ST_LOAD_A: begin
                    if (in_valid) begin
                        alu_A_flat[ELEM_W*elem_cnt +: ELEM_W] <= in_data;
                        elem_cnt <= (elem_cnt == LAST_IDX) ? '0 : elem_cnt + cnt_t'(1);
                    end
                end
                ST_LOAD_B: begin
                    if (in_valid) begin
                        alu_B_flat[ELEM_W*elem_cnt +: ELEM_W] <= in_data;
                        elem_cnt <= (elem_cnt == LAST_IDX) ? '0 : elem_cnt + cnt_t'(1);
                    end
                end
                ST_EXEC: tmo_cnt <= '0;
                ST_WAIT_DONE: begin
                    if (alu_done)     status_ovf <= alu_ovf;
                    else if (tmo_hit) status_err <= 1'b1;
                    else              tmo_cnt    <= tmo_cnt + TMO_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Result holding register and output stream.
    matrix_elem_serializer u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .c_flat    (alu_C_flat),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule
